// File: rtl/data_mem_arbiter_if.sv
// Bus bundle between the two memory requesters (cpu, debug/loader) and the
// single synchronous data-memory port.
interface data_mem_arbiter_if;
    // processor requester
    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_gnt;
    logic        cpu_rvalid;
    logic [31:0] cpu_rdata;

    // debug / loader requester
    logic        dbg_req;
    logic        dbg_we;
    logic [31:0] dbg_addr;
    logic [31:0] dbg_wdata;
    logic        dbg_gnt;
    logic        dbg_rvalid;
    logic [31:0] dbg_rdata;
    logic        dbg_starved;

    // shared memory port
    logic [31:0] dAddress;
    logic        MemWrite;
    logic [31:0] dWriteData;
    logic [31:0] dReadData;

    // arbiter side
    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_gnt, cpu_rvalid, cpu_rdata,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
        output dbg_gnt, dbg_rvalid, dbg_rdata, dbg_starved,
        output dAddress, MemWrite, dWriteData,
        input  dReadData
    );

    // requester / memory side
    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_gnt, cpu_rvalid, cpu_rdata,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata,
        input  dbg_gnt, dbg_rvalid, dbg_rdata, dbg_starved,
        input  dAddress, MemWrite, dWriteData,
        output dReadData
    );
endinterface

// File: rtl/data_mem_arbiter.sv
// Fixed-priority (cpu first) arbiter for the shared data-memory port, with a
// starvation counter that forces a debug grant after STARVE_LIMIT denials.
module data_mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic               clk,
    input  logic               rst,
    data_mem_arbiter_if.slave  bus
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_DBG  = 2'd2
    } owner_e;

    owner_e           owner_q, owner_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

    logic        cpu_gnt_c;
    logic        dbg_gnt_c;
    logic        starved_c;
    logic        mem_we_c;
    logic [31:0] mem_addr_c;
    logic [31:0] mem_wdata_c;
    logic        cpu_rvalid_c;
    logic        dbg_rvalid_c;

    // state register: read owner and debug starvation count
    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q    <= OWN_NONE;
            wait_cnt_q <= '0;
        end else begin
            owner_q    <= owner_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // grant decision, memory mux and next-state
    always_comb begin
        cpu_gnt_c   = 1'b0;
        dbg_gnt_c   = 1'b0;
        mem_we_c    = 1'b0;
        mem_addr_c  = bus.cpu_addr;
        mem_wdata_c = bus.cpu_wdata;
        owner_d     = OWN_NONE;
        wait_cnt_d  = '0;
        starved_c   = !rst && (wait_cnt_q == LIMIT);

        if (!rst) begin
            if (starved_c && bus.dbg_req) begin
                dbg_gnt_c = 1'b1;
            end else if (bus.cpu_req) begin
                cpu_gnt_c = 1'b1;
            end else if (bus.dbg_req) begin
                dbg_gnt_c = 1'b1;
            end
        end

        if (dbg_gnt_c) begin
            mem_we_c    = bus.dbg_we;
            mem_addr_c  = bus.dbg_addr;
            mem_wdata_c = bus.dbg_wdata;
        end else if (cpu_gnt_c) begin
            mem_we_c    = bus.cpu_we;
        end

        // write grants return no data, so they leave no owner behind
        if (cpu_gnt_c && !bus.cpu_we) begin
            owner_d = OWN_CPU;
        end else if (dbg_gnt_c && !bus.dbg_we) begin
            owner_d = OWN_DBG;
        end

        if (bus.dbg_req && !dbg_gnt_c) begin
            wait_cnt_d = (wait_cnt_q == LIMIT) ? wait_cnt_q : wait_cnt_q + CNT_W'(1);
        end
    end

    // reset also masks a return that was in flight when it arrived
    assign cpu_rvalid_c = !rst && (owner_q == OWN_CPU);
    assign dbg_rvalid_c = !rst && (owner_q == OWN_DBG);

    assign bus.cpu_gnt     = cpu_gnt_c;
    assign bus.dbg_gnt     = dbg_gnt_c;
    assign bus.dbg_starved = starved_c;
    assign bus.MemWrite    = mem_we_c;
    assign bus.dAddress    = mem_addr_c;
    assign bus.dWriteData  = mem_wdata_c;
    assign bus.cpu_rvalid  = cpu_rvalid_c;
    assign bus.dbg_rvalid  = dbg_rvalid_c;
    assign bus.cpu_rdata   = cpu_rvalid_c ? bus.dReadData : 32'h0;
    assign bus.dbg_rdata   = dbg_rvalid_c ? bus.dReadData : 32'h0;

    a_write_needs_grant : assert property (@(posedge clk) disable iff (rst)
        bus.MemWrite |-> (cpu_gnt_c || dbg_gnt_c));
    a_one_grant : assert property (@(posedge clk) !(cpu_gnt_c && dbg_gnt_c));
    a_cnt_bound : assert property (@(posedge clk) disable iff (rst) wait_cnt_q <= LIMIT);

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: directed scenarios plus constrained-random
// requesters, all checked against a cycle-level behavioural model.
module tb_data_mem_arbiter;

    localparam int LIMIT = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    data_mem_arbiter_if bus();

    data_mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // synchronous memory behind the port
    logic [31:0] mem [256];
    always @(posedge clk) begin
        if (bus.MemWrite) mem[bus.dAddress[9:2]] <= bus.dWriteData;
        bus.dReadData <= mem[bus.dAddress[9:2]];
    end

    // reference model state
    logic [31:0] ref_mem [256];
    int          m_wait = 0;
    int          m_pend = 0;
    logic [31:0] m_pend_data = 32'h0;
    int          m_owner = 0;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // settle mid-cycle, predict this cycle's outputs and compare
    task automatic eval_cycle();
        logic        st;
        logic [31:0] ea, ew;
        logic        emw;
        #4;
        st = !rst && (m_wait == LIMIT);
        if (rst)                      m_owner = 0;
        else if (st && bus.dbg_req)   m_owner = 2;
        else if (bus.cpu_req)         m_owner = 1;
        else if (bus.dbg_req)         m_owner = 2;
        else                          m_owner = 0;
        ea  = (m_owner == 2) ? bus.dbg_addr  : bus.cpu_addr;
        ew  = (m_owner == 2) ? bus.dbg_wdata : bus.cpu_wdata;
        emw = (m_owner == 1) ? bus.cpu_we : (m_owner == 2) ? bus.dbg_we : 1'b0;
        check_eq("starved",    32'(bus.dbg_starved), 32'(st));
        check_eq("cpu_gnt",    32'(bus.cpu_gnt),     32'(m_owner == 1));
        check_eq("dbg_gnt",    32'(bus.dbg_gnt),     32'(m_owner == 2));
        check_eq("memwrite",   32'(bus.MemWrite),    32'(emw));
        check_eq("daddress",   bus.dAddress,         ea);
        check_eq("dwritedata", bus.dWriteData,       ew);
        check_eq("cpu_rvalid", 32'(bus.cpu_rvalid),  32'(!rst && m_pend == 1));
        check_eq("dbg_rvalid", 32'(bus.dbg_rvalid),  32'(!rst && m_pend == 2));
        check_eq("cpu_rdata",  bus.cpu_rdata, (!rst && m_pend == 1) ? m_pend_data : 32'h0);
        check_eq("dbg_rdata",  bus.dbg_rdata, (!rst && m_pend == 2) ? m_pend_data : 32'h0);
    endtask

    // clock edge: commit the granted access into the model
    task automatic advance();
        logic        we;
        logic [31:0] a, wd;
        @(posedge clk);
        if (rst) begin
            m_wait = 0;
            m_pend = 0;
        end else begin
            we = (m_owner == 2) ? bus.dbg_we    : bus.cpu_we;
            a  = (m_owner == 2) ? bus.dbg_addr  : bus.cpu_addr;
            wd = (m_owner == 2) ? bus.dbg_wdata : bus.cpu_wdata;
            m_pend = 0;
            if (m_owner != 0) begin
                if (we) ref_mem[a[9:2]] = wd;
                else begin
                    m_pend      = m_owner;
                    m_pend_data = ref_mem[a[9:2]];
                end
            end
            if (!bus.dbg_req || m_owner == 2) m_wait = 0;
            else if (m_wait < LIMIT)          m_wait++;
        end
        #1;
    endtask

    task automatic cyc();
        eval_cycle();
        advance();
    endtask

    task automatic set_cpu(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
        bus.cpu_req = r; bus.cpu_we = w; bus.cpu_addr = a; bus.cpu_wdata = d;
    endtask

    task automatic set_dbg(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
        bus.dbg_req = r; bus.dbg_we = w; bus.dbg_addr = a; bus.dbg_wdata = d;
    endtask

    function automatic logic [31:0] rand_addr();
        return 32'h0080_0000 | (32'($urandom_range(0, 15)) << 2);
    endfunction

    initial begin
        for (int i = 0; i < 256; i++) begin
            ref_mem[i] = $urandom;
            mem[i]     = ref_mem[i];
        end
        rst = 1'b1;
        set_cpu(1'b1, 1'b0, 32'h0080_0000, 32'h0);
        set_dbg(1'b1, 1'b0, 32'h0080_0004, 32'h0);

        // reset with both requesting
        for (int i = 0; i < 2; i++) begin
            eval_cycle();
            check_eq("rst_cpu_gnt",  32'(bus.cpu_gnt), 32'h0);
            check_eq("rst_dbg_gnt",  32'(bus.dbg_gnt), 32'h0);
            check_eq("rst_memwrite", 32'(bus.MemWrite), 32'h0);
            check_eq("rst_rvalid",   32'({bus.cpu_rvalid, bus.dbg_rvalid}), 32'h0);
            check_eq("rst_starved",  32'(bus.dbg_starved), 32'h0);
            advance();
        end
        rst = 1'b0;
        set_cpu(1'b0, 1'b0, 32'h0, 32'h0);
        set_dbg(1'b0, 1'b0, 32'h0, 32'h0);
        cyc();

        // cpu only: write then read back
        set_cpu(1'b1, 1'b1, 32'h0080_0010, 32'hDEAD_BEEF);
        eval_cycle();
        check_eq("cpu_wr_gnt", 32'(bus.cpu_gnt), 32'h1);
        check_eq("cpu_wr_mw",  32'(bus.MemWrite), 32'h1);
        advance();
        set_cpu(1'b1, 1'b0, 32'h0080_0010, 32'h0);
        eval_cycle();
        check_eq("cpu_rd_gnt", 32'(bus.cpu_gnt), 32'h1);
        advance();
        set_cpu(1'b0, 1'b0, 32'h0, 32'h0);
        eval_cycle();
        check_eq("cpu_rd_valid", 32'(bus.cpu_rvalid), 32'h1);
        check_eq("cpu_rd_data",  bus.cpu_rdata, 32'hDEAD_BEEF);
        check_eq("cpu_rd_dbgv",  32'(bus.dbg_rvalid), 32'h0);
        advance();

        // interleaved return
        set_cpu(1'b1, 1'b1, 32'h0080_0000, 32'h11); cyc();
        set_cpu(1'b1, 1'b1, 32'h0080_0004, 32'h22); cyc();
        set_cpu(1'b1, 1'b0, 32'h0080_0000, 32'h0);  cyc();
        set_cpu(1'b0, 1'b0, 32'h0, 32'h0);
        set_dbg(1'b1, 1'b0, 32'h0080_0004, 32'h0);
        eval_cycle();
        check_eq("il_cpu_data", bus.cpu_rdata, 32'h11);
        check_eq("il_dbg_v1",   32'(bus.dbg_rvalid), 32'h0);
        advance();
        set_dbg(1'b0, 1'b0, 32'h0, 32'h0);
        eval_cycle();
        check_eq("il_dbg_data", bus.dbg_rdata, 32'h22);
        check_eq("il_cpu_v2",   32'(bus.cpu_rvalid), 32'h0);
        advance();

        // contention: debug wins every ninth cycle
        set_cpu(1'b1, 1'b0, 32'h0080_0000, 32'h0);
        set_dbg(1'b1, 1'b0, 32'h0080_0004, 32'h0);
        for (int i = 0; i < 27; i++) begin
            eval_cycle();
            check_eq("cont_gnt", 32'({bus.cpu_gnt, bus.dbg_gnt}),
                     (i % 9 == 8) ? 32'h1 : 32'h2);
            check_eq("cont_starved", 32'(bus.dbg_starved), 32'(i % 9 == 8));
            advance();
        end
        set_cpu(1'b0, 1'b0, 32'h0, 32'h0);
        set_dbg(1'b0, 1'b0, 32'h0, 32'h0);
        cyc();

        // write suppression: dbg write lands only on its grant
        set_cpu(1'b1, 1'b0, 32'h0080_0020, 32'h0);
        set_dbg(1'b1, 1'b1, 32'h0080_0020, 32'hCAFE_F00D);
        for (int i = 0; i < 9; i++) begin
            eval_cycle();
            check_eq("ws_memwrite", 32'(bus.MemWrite), 32'(i == 8));
            if (i == 8) check_eq("ws_addr", bus.dAddress, 32'h0080_0020);
            advance();
        end
        set_dbg(1'b0, 1'b0, 32'h0, 32'h0);
        cyc();
        eval_cycle();
        check_eq("ws_readback", bus.cpu_rdata, 32'hCAFE_F00D);
        advance();

        // reset mid-read
        set_cpu(1'b1, 1'b0, 32'h0080_0010, 32'h0);
        cyc();
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            eval_cycle();
            check_eq("rmr_valid", 32'(bus.cpu_rvalid), 32'h0);
            check_eq("rmr_data",  bus.cpu_rdata, 32'h0);
            advance();
        end
        rst = 1'b0;
        set_cpu(1'b0, 1'b0, 32'h0, 32'h0);
        eval_cycle();
        check_eq("rmr_after", 32'(bus.cpu_rvalid), 32'h0);
        advance();

        // random traffic obeying the hold-until-grant protocol
        for (int i = 0; i < 800; i++) begin
            rst = ($urandom_range(0, 99) == 0);
            eval_cycle();
            advance();
            if (!bus.cpu_req || m_owner == 1)
                set_cpu($urandom_range(0, 2) != 0, $urandom_range(0, 2) == 0, rand_addr(), $urandom);
            else if ($urandom_range(0, 15) == 0)
                bus.cpu_req = 1'b0;
            if (!bus.dbg_req || m_owner == 2)
                set_dbg($urandom_range(0, 2) != 0, $urandom_range(0, 2) == 0, rand_addr(), $urandom);
            else if ($urandom_range(0, 15) == 0)
                bus.dbg_req = 1'b0;
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/data_mem_arbiter.md
# data_mem_arbiter

Two-port arbiter sharing the single data-memory port of the RISC-V memory block between the processor data path and a debug/loader requester, such as a UART program loader. It sits between both requesters and the memory's `dAddress`/`MemWrite`/`dWriteData`/`dReadData` port. The processor has fixed priority, and a starvation counter guarantees the debug port forward progress. Read data is returned on the requester that owned the port in the previous cycle, matching the memory's one-cycle synchronous read.

## Interface
- `STARVE_LIMIT`, 8: consecutive cycles the debug port may be denied before it wins one grant; legal range 1–255.
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `cpu_req`  in  1  processor requests a memory access this cycle.
- `cpu_we`  in  1  processor access is a write.
- `cpu_addr`  in  32  processor byte address.
- `cpu_wdata`  in  32  processor write data.
- `cpu_gnt`  out  1  processor access is issued this cycle (combinational).
- `cpu_rvalid`  out  1  `cpu_rdata` holds read data for the processor's previous-cycle grant.
- `cpu_rdata`  out  32  read data to the processor.
- `dbg_req`, `dbg_we`, `dbg_addr` (32), `dbg_wdata` (32): debug requester inputs, same meaning as the `cpu_*` inputs.
- `dbg_gnt`, `dbg_rvalid`, `dbg_rdata` (32): debug requester outputs, same meaning as the `cpu_*` outputs.
- `dAddress`  out  32  memory address.
- `MemWrite`  out  1  memory write strobe.
- `dWriteData`  out  32  memory write data.
- `dReadData`  in  32  memory synchronous read data, valid the cycle after an address is presented.
- `dbg_starved`  out  1  starvation counter is at `STARVE_LIMIT`, so debug has priority this cycle.

## Operation
- **Grant rule (combinational, one grant per cycle at most)**
  - If `dbg_starved` and `dbg_req`: grant debug.
  - Else if `cpu_req`: grant the processor.
  - Else if `dbg_req`: grant debug.
  - Else: no grant.
- **Memory mux**
  - The granted requester drives `dAddress`, `dWriteData`, and `MemWrite = we`.
  - With no grant: `MemWrite = 0`, and `dAddress`/`dWriteData` are driven from the cpu inputs. This makes a harmless read.
  - `MemWrite` is never 1 without a grant.
- **Starvation counter (8 bits, `wait_cnt`)**
  - Increments when `dbg_req` && !`dbg_gnt`.
  - Clears to 0 on `dbg_gnt`, or when `dbg_req` = 0.
  - Saturates at `STARVE_LIMIT`.
  - `dbg_starved` = (`wait_cnt` == `STARVE_LIMIT`).
- **Owner register (`last_owner`)**
  - States: NONE, CPU, DBG.
  - Next state = CPU if `cpu_gnt` && !`cpu_we`; DBG if `dbg_gnt` && !`dbg_we`; otherwise NONE.
  - Write grants return no read data.
- **Read return**
  - `cpu_rvalid` = (`last_owner` == CPU); `dbg_rvalid` = (`last_owner` == DBG). Both are decoded from registered state.
  - `x_rdata` = `dReadData` when `x_rvalid`, else 32'h0.
- **Requester protocol**
  - A requester holds `req`/`we`/`addr`/`wdata` stable until it sees `gnt`.
  - A requester may drop `req` without a grant; the dropped access is never issued.
- **Address handling:** no address decode. The memory's own data-space check applies.

## Timing
- Reset values: `last_owner` = NONE, `wait_cnt` = 0. Therefore `cpu_rvalid` = `dbg_rvalid` = 0, both `rdata` = 0, and `dbg_starved` = 0.
- While `rst` is high, both grants are forced to 0 and `MemWrite` = 0.
- Grant latency: 0 cycles. `gnt` is asserted in the same cycle as `req` when the port is won.
- Read latency: 1 cycle from grant to `rvalid`. Back-to-back reads return one word per cycle.
- Simultaneous requests with `wait_cnt` < `STARVE_LIMIT`: the processor wins, and the counter increments.
- Continuous `cpu_req` with `dbg_req` held: debug is granted on exactly every (`STARVE_LIMIT`+1)th cycle. The processor sees `cpu_gnt` = 0 on that cycle and must stall.
- Reset asserted the cycle after a read grant: `rvalid` is 0 on the following cycle, and the read is discarded.
- Write followed by a read of the same address on the next cycle: the read returns the new data, relying on the memory's write-before-read ordering.

## Test plan
- **Reset:** hold `rst` for 2 cycles with both `req` = 1 -> both `gnt` = 0, `MemWrite` = 0, both `rvalid` = 0, `dbg_starved` = 0.
- **CPU only:** cpu write 0xDEADBEEF to 0x00800010, then read it back -> `cpu_gnt` = 1 both cycles; `cpu_rvalid` = 1 with `cpu_rdata` = 0xDEADBEEF one cycle after the read grant; `dbg_rvalid` stays 0.
- **Contention:** both requesters request reads every cycle, `STARVE_LIMIT` = 8 -> cycles 0–7 grant cpu, cycle 8 grants dbg with `dbg_starved` = 1, and the pattern repeats. `wait_cnt` returns to 0 after each dbg grant.
- **Interleaved return:** cpu read 0x00800000 (data 0x11), then dbg read 0x00800004 (data 0x22) in consecutive cycles -> cpu gets `rdata` 0x11 at t+1 and dbg gets 0x22 at t+2, with no cross-delivery.
- **Write suppression:** dbg write issued while `cpu_req` = 1 and `wait_cnt` = 0 -> `MemWrite` carries the cpu access only; the dbg write lands only on its grant cycle, which a readback confirms.
- **Reset mid-read:** grant a cpu read, assert `rst` the next cycle -> `cpu_rvalid` = 0 and `cpu_rdata` = 0 during and after reset.
